// File: rtl/mixcolumn_pkg.sv
// Shared AES constants, types and GF(2^8) helpers for the MixColumns stage.
// gmul() backs the inverse coefficients enabled by INV_MIX_EN.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;
  localparam int BYTE_W  = 8;
  localparam int NCOL    = 4;
  localparam int CNT_W   = $clog2(NCOL);

  localparam logic [BYTE_W-1:0] AES_POLY = 8'h1B;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MIX  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    MIX  = ST_MIX,
    DONE = ST_DONE
  } fsm_state_e;

  // Index NCOL-1 holds column 0 so the packed view matches the bus bit order.
  typedef logic [NCOL-1:0][COL_W-1:0] block_t;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [BYTE_W-1:0] gmul(input logic [BYTE_W-1:0] a,
                                             input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < BYTE_W; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/mixcolumn_if.sv
// Handshake/data bundle between ShiftRows, MixColumns and AddRoundKey.
// The decrypt select only exists when INV_MIX_EN is defined.
interface mixcolumn_if;
  import aes_pkg::*;

  logic [STATE_W-1:0] plain_row;
  logic               ok_row;
  logic               is_last;
`ifdef INV_MIX_EN
  logic               decrypt;
`endif
  logic [STATE_W-1:0] plain_mix;
  logic               ok_mix;
  logic               busy;
  logic               overrun;

  modport master (
`ifdef INV_MIX_EN
    output decrypt,
`endif
    output plain_row, ok_row, is_last,
    input  plain_mix, ok_mix, busy, overrun
  );

  modport slave (
`ifdef INV_MIX_EN
    input  decrypt,
`endif
    input  plain_row, ok_row, is_last,
    output plain_mix, ok_mix, busy, overrun
  );

endinterface

// File: rtl/mixcolumn_mix_col.sv
// Combinational single-column mixer: forward MixColumns or, with inv=1,
// InvMixColumns. Byte a0 (row 0) is the most significant byte.
module mix_col
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  input  logic             inv,
  output logic [COL_W-1:0] col_out
);

  logic [BYTE_W-1:0] a0, a1, a2, a3;
  logic [BYTE_W-1:0] f0, f1, f2, f3;
  logic [BYTE_W-1:0] i0, i1, i2, i3;

  assign {a0, a1, a2, a3} = col_in;

  // Forward matrix rows are rotations of {02,03,01,01}; 03*x = xtime(x)^x.
  assign f0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
  assign f1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
  assign f2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
  assign f3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

  assign i0 = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
  assign i1 = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
  assign i2 = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
  assign i3 = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);

  assign col_out = inv ? {i0, i1, i2, i3} : {f0, f1, f2, f3};

endmodule

// File: rtl/mixcolumn.sv
// Iterative AES MixColumns stage: one column per clock through a shared mixer,
// final round bypassed. Define INV_MIX_EN to add the decrypt (InvMixColumns) select.
module mixcolumn
  import aes_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  mixcolumn_if.slave bus
);

  fsm_state_e         state_q, state_d;
  logic [CNT_W-1:0]   col_cnt_q, col_cnt_d;
  block_t             work_q, work_d;
  logic [STATE_W-1:0] plain_mix_q, plain_mix_d;
  logic               ok_mix_q, ok_mix_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic               inv_sel;
  logic [CNT_W-1:0]   col_idx;
  logic [COL_W-1:0]   mixed_col;

`ifdef INV_MIX_EN
  logic decrypt_q, decrypt_d;
  assign inv_sel = decrypt_q;
`else
  assign inv_sel = 1'b0;
`endif

  assign col_idx = CNT_W'(NCOL - 1) - col_cnt_q;

  mix_col u_mix_col (
    .col_in  (work_q[col_idx]),
    .inv     (inv_sel),
    .col_out (mixed_col)
  );

  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    work_d      = work_q;
    plain_mix_d = plain_mix_q;
    ok_mix_d    = 1'b0;
    overrun_d   = 1'b0;
`ifdef INV_MIX_EN
    decrypt_d   = decrypt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.ok_row) begin
          if (bus.is_last) begin
            plain_mix_d = bus.plain_row;
            ok_mix_d    = 1'b1;
            state_d     = DONE;
          end else begin
            work_d    = bus.plain_row;
            col_cnt_d = '0;
            state_d   = MIX;
`ifdef INV_MIX_EN
            decrypt_d = bus.decrypt;
`endif
          end
        end
      end
      MIX: begin
        overrun_d       = bus.ok_row;
        work_d[col_idx] = mixed_col;
        col_cnt_d       = col_cnt_q + 1'b1;
        if (col_cnt_q == CNT_W'(NCOL - 1)) begin
          plain_mix_d = work_d;
          ok_mix_d    = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        overrun_d = bus.ok_row;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered, so they track the state being entered.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_cnt_q   <= '0;
      work_q      <= '0;
      plain_mix_q <= '0;
      ok_mix_q    <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef INV_MIX_EN
      decrypt_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      work_q      <= work_d;
      plain_mix_q <= plain_mix_d;
      ok_mix_q    <= ok_mix_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
`ifdef INV_MIX_EN
      decrypt_q   <= decrypt_d;
`endif
    end
  end

  assign bus.plain_mix = plain_mix_q;
  assign bus.ok_mix    = ok_mix_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_mixcolumn.sv
// Self-checking bench for mixcolumn: fixed AES vectors, bypass, overrun,
// mid-block reset and random blocks against a matrix-form GF(2^8) model.
module tb_mixcolumn;

  logic clk;
  logic rst_n;
  logic dec_sel;
  int   total;
  int   bad;

  mixcolumn_if bus ();

  mixcolumn dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry-less product then reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] refMix(input logic [127:0] s, input logic last,
                                          input logic inv);
    logic [7:0]   base [4];
    logic [127:0] res;
    logic [7:0]   acc;
    if (last) return s;
    if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ refMul(s[127 - 32*c - 8*k -: 8], base[(k - r + 4) % 4]);
        res[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic driveRow(input logic [127:0] data, input logic last);
    bus.plain_row = data;
    bus.is_last   = last;
`ifdef INV_MIX_EN
    bus.decrypt   = dec_sel;
`endif
    bus.ok_row    = 1'b1;
  endtask

  // Issues one block and waits (bounded) for its ok_mix pulse.
  task automatic applyStimulus(input logic [127:0] data, input logic last,
                               output logic [127:0] result, output int latency,
                               output int busy_cycles);
    driveRow(data, last);
    @(posedge clk); #1;
    bus.ok_row  = 1'b0;
    bus.is_last = 1'($urandom_range(0, 1));
    latency     = 0;
    busy_cycles = 0;
    result      = '0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.busy) busy_cycles++;
      if (bus.ok_mix) begin
        latency = k;
        result  = bus.plain_mix;
        break;
      end
      @(posedge clk); #1;
    end
    if (latency == 0) begin
      checkOutput("ok_mix_timeout", 128'd0, 128'd1);
    end else begin
      @(posedge clk); #1;
      checkOutput("ok_mix_single_pulse", 128'(bus.ok_mix), 128'd0);
    end
  endtask

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

  logic [127:0] res;
  logic [127:0] blk;
  logic [127:0] blk_b;
  logic         last;
  logic         saw_ok;
  int           lat;
  int           bcyc;

  initial begin
    total         = 0;
    bad           = 0;
    dec_sel       = 1'b0;
    rst_n         = 1'b0;
    bus.plain_row = '0;
    bus.ok_row    = 1'b0;
    bus.is_last   = 1'b0;
`ifdef INV_MIX_EN
    bus.decrypt   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_plain_mix", bus.plain_mix, '0);
    checkOutput("reset_ok_mix", 128'(bus.ok_mix), 128'd0);
    checkOutput("reset_busy", 128'(bus.busy), 128'd0);
    checkOutput("reset_overrun", 128'(bus.overrun), 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known single-column vectors, first alone in column 0, then one per column.
    applyStimulus({32'hdb135345, 96'h0}, 1'b0, res, lat, bcyc);
    checkOutput("col_db135345", res, {32'h8e4da1bc, 96'h0});
    blk = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
    applyStimulus(blk, 1'b0, res, lat, bcyc);
    checkOutput("col_vectors", res,
                {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6});
    checkOutput("col_vectors_model", res, refMix(blk, 1'b0, 1'b0));

    applyStimulus(FIPS_IN, 1'b0, res, lat, bcyc);
    checkOutput("fips_round1", res, FIPS_OUT);
    checkOutput("fips_latency", 128'(lat), 128'd5);
    checkOutput("fips_busy_cycles", 128'(bcyc), 128'd5);

    blk = 128'h0123456789abcdeffedcba9876543210;
    applyStimulus(blk, 1'b1, res, lat, bcyc);
    checkOutput("bypass_data", res, blk);
    checkOutput("bypass_latency", 128'(lat), 128'd1);
    checkOutput("bypass_busy_cycles", 128'(bcyc), 128'd1);

    // Second ok_row two cycles after the first is dropped with an overrun pulse.
    blk   = {$urandom, $urandom, $urandom, $urandom};
    blk_b = {$urandom, $urandom, $urandom, $urandom};
    driveRow(blk, 1'b0);
    @(posedge clk); #1;
    bus.ok_row = 1'b0;
    checkOutput("overrun_idle_before", 128'(bus.overrun), 128'd0);
    @(posedge clk); #1;
    driveRow(blk_b, 1'b0);
    @(posedge clk); #1;
    bus.ok_row = 1'b0;
    checkOutput("overrun_pulse", 128'(bus.overrun), 128'd1);
    @(posedge clk); #1;
    checkOutput("overrun_one_cycle", 128'(bus.overrun), 128'd0);
    saw_ok = 1'b0;
    for (int k = 0; k < 20 && !saw_ok; k++) begin
      if (bus.ok_mix) begin
        saw_ok = 1'b1;
        res    = bus.plain_mix;
      end else begin
        @(posedge clk); #1;
      end
    end
    checkOutput("overrun_first_seen", 128'(saw_ok), 128'd1);
    checkOutput("overrun_first_result", res, refMix(blk, 1'b0, 1'b0));

    // ok_row coinciding with ok_mix (DONE) is also dropped.
    driveRow(blk_b, 1'b0);
    @(posedge clk); #1;
    bus.ok_row = 1'b0;
    checkOutput("done_overrun", 128'(bus.overrun), 128'd1);
    checkOutput("done_drop_busy", 128'(bus.busy), 128'd0);
    saw_ok = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.ok_mix || bus.busy) saw_ok = 1'b1;
    end
    checkOutput("done_drop_no_result", 128'(saw_ok), 128'd0);
    applyStimulus(blk_b, 1'b0, res, lat, bcyc);
    checkOutput("after_overrun_block", res, refMix(blk_b, 1'b0, 1'b0));

    // Reset while the third column is being mixed.
    driveRow(FIPS_IN, 1'b0);
    @(posedge clk); #1;
    bus.ok_row = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_plain_mix", bus.plain_mix, '0);
    checkOutput("midrst_ok_mix", 128'(bus.ok_mix), 128'd0);
    checkOutput("midrst_busy", 128'(bus.busy), 128'd0);
    saw_ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == 2) rst_n = 1'b1;
      if (bus.ok_mix) saw_ok = 1'b1;
    end
    checkOutput("midrst_no_ok_mix", 128'(saw_ok), 128'd0);
    applyStimulus(FIPS_IN, 1'b0, res, lat, bcyc);
    checkOutput("midrst_fresh_block", res, FIPS_OUT);

`ifdef INV_MIX_EN
    dec_sel = 1'b1;
    applyStimulus(FIPS_OUT, 1'b0, res, lat, bcyc);
    checkOutput("inv_fips", res, FIPS_IN);
    checkOutput("inv_latency", 128'(lat), 128'd5);
    dec_sel = 1'b0;
`endif

    for (int n = 0; n < 24; n++) begin
      blk  = {$urandom, $urandom, $urandom, $urandom};
      last = ($urandom_range(0, 3) == 0);
`ifdef INV_MIX_EN
      dec_sel = 1'($urandom_range(0, 1));
`endif
      applyStimulus(blk, last, res, lat, bcyc);
      checkOutput($sformatf("rand_data_%0d", n), res, refMix(blk, last, dec_sel));
      checkOutput($sformatf("rand_latency_%0d", n), 128'(lat), last ? 128'd1 : 128'd5);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
